// File: rtl/processador_pio_pkg.sv
// -----------------------------------------------------------------------------
// processador_pio_pkg
// Shared definitions for the PIO poller: CPU register offsets, CONTROL bit
// positions, poll FSM state encoding and the poll-interval helper.
// -----------------------------------------------------------------------------
package processador_pio_pkg;

  // CPU slave register map
  localparam logic [1:0] ADDR_EVENT   = 2'd0;
  localparam logic [1:0] ADDR_CONTROL = 2'd1;
  localparam logic [1:0] ADDR_PERIOD  = 2'd2;
  localparam logic [1:0] ADDR_LEVEL   = 2'd3;

  // CONTROL register bit positions
  localparam int CTRL_ENABLE_BIT   = 0;
  localparam int CTRL_IRQ_EN_BIT   = 1;
  localparam int CTRL_OVERFLOW_BIT = 2;

  // Poll FSM states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_COMPARE = 3'd4
  } poll_state_e;

  // A programmed period of zero is treated as one clock.
  function automatic logic [15:0] eff_period(input logic [15:0] period);
    if (period == 16'd0) begin
      return 16'd1;
    end else begin
      return period;
    end
  endfunction

endpackage

// File: rtl/processador_pio_event_fifo.sv
// -----------------------------------------------------------------------------
// processador_pio_event_fifo
// Small synchronous FIFO holding change events. Push, pop and flush are all
// synchronous; flush has priority over a simultaneous push/pop. A push into a
// full FIFO is accepted only when a pop happens in the same cycle.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   push_i, wdata_i   write request and data
//   pop_i             read-advance request (ignored when empty)
//   flush_i           empties the FIFO
//   rdata_o           head entry (valid when empty_o is low)
//   full_o, empty_o   status flags
//   level_o           number of stored entries
// -----------------------------------------------------------------------------
module processador_pio_event_fifo #(
  parameter int DW    = 6,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          do_push_s;
  logic          do_pop_s;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == {LW{1'b0}});
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop_s  = pop_i & ~empty_o;
  assign do_push_s = push_i & (~full_o | do_pop_s);

  // Pointer and level bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {LW{1'b0}};
    end else if (flush_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {LW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      level_q <= level_q + LW'(do_push_s) - LW'(do_pop_s);
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push_s && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/processador_pio_poller.sv
// -----------------------------------------------------------------------------
// processador_pio_poller
// Periodically reads an input PIO, compares the sampled bits with the previous
// sample and queues a change event (changed mask + new value) for the CPU.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   m_address, m_read, m_readdata     master port to the input PIO
//                                     (read data arrives one clock after m_read)
//   s_address, s_read, s_write,
//   s_writedata, s_readdata           CPU slave port, one-clock read latency
//   irq                               level interrupt
// Registers: 0 EVENT (read pops), 1 CONTROL {overflow(W1C), irq_en, enable},
//            2 PERIOD[15:0], 3 LEVEL (read = count, write = flush).
// -----------------------------------------------------------------------------
module processador_pio_poller
  import processador_pio_pkg::*;
#(
  parameter int WIDTH        = 3,
  parameter int FIFO_DEPTH   = 4,
  parameter int PERIOD_RESET = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  m_address,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  input  logic [1:0]  s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        irq
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = 2 * WIDTH;

  poll_state_e      state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [15:0]      period_q, period_d;
  logic             enable_q, enable_d;
  logic             irq_en_q, irq_en_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] sample_q, sample_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             base_valid_q, base_valid_d;
  logic             m_read_q, m_read_d;
  logic [31:0]      s_readdata_q, s_readdata_d;
  logic             irq_q, irq_d;

  logic             wr_ctrl_s, wr_period_s;
  logic             en_eff_s;
  logic             push_s, pop_s, flush_s;
  logic [EW-1:0]    fifo_rdata_s;
  logic             fifo_full_s, fifo_empty_s;
  logic [LW-1:0]    fifo_level_s;
  logic [15:0]      reload_s;
  logic [31:0]      event_word_s;
  logic             unused_s;

  assign wr_ctrl_s   = s_write && (s_address == ADDR_CONTROL);
  assign wr_period_s = s_write && (s_address == ADDR_PERIOD);
  assign flush_s     = s_write && (s_address == ADDR_LEVEL);
  assign pop_s       = s_read && (s_address == ADDR_EVENT) && !fifo_empty_s;

  // The FSM reacts to an enable write in the same clock it is presented.
  assign en_eff_s = wr_ctrl_s ? s_writedata[CTRL_ENABLE_BIT] : enable_q;

  // The COMPARE clock counts as the first tick of the interval, so the
  // ISSUE-to-ISSUE spacing is PERIOD+2 clocks.
  assign reload_s = eff_period(period_q) - 16'd1;

  assign m_address  = 2'b00;
  assign m_read     = m_read_q;
  assign s_readdata = s_readdata_q;
  assign irq        = irq_q;

  // Bits of the PIO and CPU data buses this block has no use for
  assign unused_s = ^{m_readdata[31:WIDTH], s_writedata[31:16]};

  processador_pio_event_fifo #(
    .DW    (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push_s),
    .wdata_i ({sample_q ^ last_q, sample_q}),
    .pop_i   (pop_s),
    .flush_i (flush_s),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .level_o (fifo_level_s)
  );

  // Poll FSM next-state and sample/baseline tracking
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sample_d     = sample_q;
    last_d       = last_q;
    base_valid_d = base_valid_q;
    push_s       = 1'b0;
    if (!en_eff_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d   = reload_s;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_q <= 16'd1) begin
            cnt_d   = 16'd0;
            state_d = ST_ISSUE;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        ST_ISSUE: begin
          state_d = ST_CAPTURE;
        end
        ST_CAPTURE: begin
          sample_d = m_readdata[WIDTH-1:0];
          state_d  = ST_COMPARE;
        end
        ST_COMPARE: begin
          // The very first sample only establishes the baseline.
          push_s       = base_valid_q && (sample_q != last_q);
          last_d       = sample_q;
          base_valid_d = 1'b1;
          cnt_d        = reload_s;
          state_d      = ST_WAIT;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Head of the FIFO formatted as an EVENT word
  always_comb begin
    event_word_s = 32'd0;
    if (!fifo_empty_s) begin
      event_word_s[31]          = 1'b1;
      event_word_s[WIDTH+7:8]   = fifo_rdata_s[EW-1:WIDTH];
      event_word_s[WIDTH-1:0]   = fifo_rdata_s[WIDTH-1:0];
    end else begin
      event_word_s = 32'd0;
    end
  end

  // CPU register file, read mux and interrupt
  always_comb begin
    period_d     = wr_period_s ? s_writedata[15:0] : period_q;
    enable_d     = en_eff_s;
    irq_en_d     = wr_ctrl_s ? s_writedata[CTRL_IRQ_EN_BIT] : irq_en_q;
    ovf_d        = ovf_q;
    s_readdata_d = s_readdata_q;
    if (wr_ctrl_s && s_writedata[CTRL_OVERFLOW_BIT]) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    // A dropped event sets overflow even if a clear arrives in the same clock.
    if (push_s && fifo_full_s && !pop_s && !flush_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_d;
    end
    if (s_read) begin
      case (s_address)
        ADDR_EVENT:   s_readdata_d = event_word_s;
        ADDR_CONTROL: s_readdata_d = {29'd0, ovf_q, irq_en_q, enable_q};
        ADDR_PERIOD:  s_readdata_d = {16'd0, period_q};
        ADDR_LEVEL:   s_readdata_d = 32'(fifo_level_s);
        default:      s_readdata_d = 32'd0;
      endcase
    end else begin
      s_readdata_d = s_readdata_q;
    end
    irq_d    = irq_en_q && (!fifo_empty_s || ovf_q);
    m_read_d = (state_d == ST_ISSUE);
  end

  // State and register update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 16'd0;
      period_q     <= 16'(PERIOD_RESET);
      enable_q     <= 1'b0;
      irq_en_q     <= 1'b0;
      ovf_q        <= 1'b0;
      sample_q     <= {WIDTH{1'b0}};
      last_q       <= {WIDTH{1'b0}};
      base_valid_q <= 1'b0;
      m_read_q     <= 1'b0;
      s_readdata_q <= 32'd0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      enable_q     <= enable_d;
      irq_en_q     <= irq_en_d;
      ovf_q        <= ovf_d;
      sample_q     <= sample_d;
      last_q       <= last_d;
      base_valid_q <= base_valid_d;
      m_read_q     <= m_read_d;
      s_readdata_q <= s_readdata_d;
      irq_q        <= irq_d;
    end
  end

endmodule

// File: tb/tb_processador_pio_poller.sv
// -----------------------------------------------------------------------------
// tb_processador_pio_poller
// Directed scenarios followed by a randomized phase. A transaction-level model
// (event queue, register values, poll pipeline of ISSUE/CAPTURE/COMPARE
// clocks) predicts CPU read data and irq.
// -----------------------------------------------------------------------------
module tb_processador_pio_poller;

  localparam int W     = 3;
  localparam int DEPTH = 4;
  localparam int PRST  = 1000;

  logic        clk;
  logic        reset_n;
  logic [1:0]  m_address;
  logic        m_read;
  logic [31:0] m_readdata;
  logic [1:0]  s_address;
  logic        s_read;
  logic        s_write;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  logic        irq;
  logic [W-1:0] in_port;

  int n_pass  = 0;
  int n_total = 0;

  processador_pio_poller #(.WIDTH(W), .FIFO_DEPTH(DEPTH), .PERIOD_RESET(PRST)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .m_address   (m_address),
    .m_read      (m_read),
    .m_readdata  (m_readdata),
    .s_address   (s_address),
    .s_read      (s_read),
    .s_write     (s_write),
    .s_writedata (s_writedata),
    .s_readdata  (s_readdata),
    .irq         (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Input PIO: registered read data, upper bits are random junk.
  always @(posedge clk) begin
    m_readdata <= ({$urandom} & ~32'd7) | 32'(in_port);
  end

  // ---------------- reference model ----------------
  logic [2*W-1:0] mq[$];
  logic           md_en, md_irqen, md_ovf, md_base;
  logic [15:0]    md_period;
  logic [W-1:0]   md_last, md_pv;
  int             md_pend;
  logic [31:0]    exp_rd;
  logic           exp_irq;

  function automatic logic [31:0] fmt(input logic [2*W-1:0] e);
    logic [31:0] r;
    r = 32'd0;
    r[31] = 1'b1;
    r[W+7:8] = e[2*W-1:W];
    r[W-1:0] = e[W-1:0];
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    logic irq_nx, do_pop, do_push, en_next, flush;
    logic [2*W-1:0] ev;
    if (!reset_n) begin
      md_en = 1'b0; md_irqen = 1'b0; md_ovf = 1'b0; md_base = 1'b0;
      md_period = 16'(PRST); md_last = '0; md_pv = '0; md_pend = 0;
      mq.delete(); exp_rd = 32'd0; exp_irq = 1'b0;
    end else begin
      irq_nx = md_irqen && (mq.size() != 0 || md_ovf);
      do_pop = 1'b0; do_push = 1'b0; ev = '0;
      if (s_read) begin
        case (s_address)
          2'd0: begin
            if (mq.size() != 0) begin exp_rd = fmt(mq[0]); do_pop = 1'b1; end
            else exp_rd = 32'd0;
          end
          2'd1: exp_rd = {29'd0, md_ovf, md_irqen, md_en};
          2'd2: exp_rd = {16'd0, md_period};
          default: exp_rd = 32'(mq.size());
        endcase
      end
      en_next = (s_write && s_address == 2'd1) ? s_writedata[0] : md_en;
      // poll pipeline: sample taken at the ISSUE edge, compared two edges later
      if (!en_next) md_pend = 0;
      else if (md_pend > 0) begin
        md_pend--;
        if (md_pend == 0) begin
          if (md_base && md_pv != md_last) begin do_push = 1'b1; ev = {md_pv ^ md_last, md_pv}; end
          md_last = md_pv;
          md_base = 1'b1;
        end
      end
      if (en_next && m_read === 1'b1) begin md_pend = 2; md_pv = in_port; end
      if (s_write && s_address == 2'd1) begin
        md_en = s_writedata[0]; md_irqen = s_writedata[1];
        if (s_writedata[2]) md_ovf = 1'b0;
      end
      if (s_write && s_address == 2'd2) md_period = s_writedata[15:0];
      flush = s_write && s_address == 2'd3;
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        if (mq.size() < DEPTH) mq.push_back(ev);
        else if (!flush) md_ovf = 1'b1;
      end
      if (flush) mq.delete();
      exp_irq = irq_nx;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    s_write = 1'b1; s_address = a; s_writedata = d;
    @(negedge clk);
    s_write = 1'b0; s_writedata = 32'd0;
  endtask

  task automatic cpu_read(input logic [1:0] a, input string tag, output logic [31:0] d);
    s_read = 1'b1; s_address = a;
    @(negedge clk);
    s_read = 1'b0;
    d = s_readdata;
    check(tag, s_readdata, exp_rd);
  endtask

  task automatic wait_mread(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_read !== 1'b1 && n < 3000);
    if (m_read !== 1'b1) check("mread_timeout", {31'd0, m_read}, 32'd1);
  endtask

  task automatic poll_change();
    int n;
    logic [W-1:0] v;
    wait_mread(n);
    idle(3);
    do v = W'($urandom_range(0, 7)); while (v == in_port);
    in_port = v;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    int n;
    s_address = 2'd0; s_read = 1'b0; s_write = 1'b0; s_writedata = 32'd0;
    in_port = '0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    idle(3);
    check("rst_m_read", {31'd0, m_read}, 32'd0);
    check("rst_m_address", {30'd0, m_address}, 32'd0);
    check("rst_s_readdata", s_readdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;
    idle(1);
    cpu_read(2'd1, "rst_control", d);
    check("rst_control_const", d, 32'd0);
    cpu_read(2'd2, "rst_period", d);
    check("rst_period_const", d, 32'd1000);
    cpu_read(2'd3, "rst_level", d);
    cpu_read(2'd0, "rst_event_empty", d);
    check("rst_event_const", d, 32'd0);

    // basic poll: PERIOD=4, 000 -> 101
    cpu_write(2'd2, 32'd4);
    cpu_write(2'd1, 32'd3);
    wait_mread(n);
    idle(2);
    in_port = 3'b101;
    wait_mread(n);
    wait_mread(n);
    check("poll_interval", 32'(n), 32'd6);
    idle(4);
    check("basic_irq", {31'd0, irq}, 32'd1);
    cpu_read(2'd3, "basic_level", d);
    check("basic_level_const", d, 32'd1);
    cpu_read(2'd0, "basic_event", d);
    check("basic_event_const", d, 32'h8000_0505);

    // overflow: five changes, no reads
    repeat (5) poll_change();
    wait_mread(n);
    idle(3);
    cpu_write(2'd1, 32'd2);
    cpu_read(2'd3, "ovf_level", d);
    check("ovf_level_const", d, 32'd4);
    cpu_read(2'd1, "ovf_control", d);
    check("ovf_control_const", d, 32'd6);
    for (int i = 0; i < 4; i++) cpu_read(2'd0, "ovf_pop", d);
    cpu_read(2'd0, "ovf_pop_empty", d);
    check("ovf_pop_empty_const", d, 32'd0);
    cpu_write(2'd1, 32'd6);

    // full FIFO: push and pop in the same clock
    cpu_write(2'd1, 32'd3);
    repeat (5) poll_change();
    wait_mread(n);
    idle(2);
    cpu_read(2'd0, "full_pushpop_event", d);
    idle(2);
    cpu_read(2'd3, "full_pushpop_level", d);
    check("full_pushpop_level_const", d, 32'd4);
    cpu_read(2'd1, "full_pushpop_ctrl", d);
    check("full_pushpop_ctrl_const", d, 32'd3);

    // enable cleared during ISSUE
    for (int i = 0; i < 4; i++) cpu_read(2'd0, "drain_pop", d);
    poll_change();
    wait_mread(n);
    cpu_write(2'd1, 32'd2);
    check("dis_m_read", {31'd0, m_read}, 32'd0);
    idle(6);
    cpu_read(2'd3, "dis_level", d);
    check("dis_level_const", d, 32'd0);
    n = 0;
    repeat (30) begin @(negedge clk); if (m_read === 1'b1) n++; end
    check("dis_no_poll", 32'(n), 32'd0);

    // reset during CAPTURE
    cpu_write(2'd1, 32'd3);
    wait_mread(n);
    idle(4);
    cpu_read(2'd1, "pre_rst_ctrl", d);
    in_port = in_port ^ 3'b010;
    wait_mread(n);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_m_read", {31'd0, m_read}, 32'd0);
    check("mid_rst_s_readdata", s_readdata, 32'd0);
    check("mid_rst_irq", {31'd0, irq}, 32'd0);
    check("mid_rst_m_address", {30'd0, m_address}, 32'd0);
    idle(2);
    reset_n = 1'b1;
    idle(1);
    cpu_read(2'd3, "post_rst_level", d);
    in_port = 3'b110;
    cpu_write(2'd2, 32'd4);
    cpu_write(2'd1, 32'd3);
    wait_mread(n);
    idle(4);
    cpu_read(2'd3, "baseline_level", d);
    check("baseline_level_const", d, 32'd0);
    in_port = 3'b011;
    wait_mread(n);
    idle(4);
    cpu_read(2'd0, "post_rst_event", d);
    check("post_rst_event_const", d, 32'h8000_0503);

    // flush coinciding with a push
    in_port = 3'b001;
    wait_mread(n);
    idle(5);
    check("flush_pre_irq", {31'd0, irq}, 32'd1);
    in_port = 3'b111;
    wait_mread(n);
    idle(2);
    cpu_write(2'd3, 32'd0);
    idle(2);
    cpu_read(2'd3, "flush_level", d);
    check("flush_level_const", d, 32'd0);
    check("flush_irq", {31'd0, irq}, 32'd0);

    // randomized phase
    cpu_write(2'd2, 32'($urandom_range(3, 8)));
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    in_port = W'($urandom_range(0, 7));
        2, 3, 4: cpu_read(2'($urandom_range(0, 3)), "rand_read", d);
        5:       cpu_read(2'd0, "rand_pop", d);
        6:       check("rand_irq", {31'd0, irq}, {31'd0, exp_irq});
        7:       if ($urandom_range(0, 7) == 0) cpu_write(2'd3, 32'd0);
                 else cpu_write(2'd1, 32'd7);
        default: idle($urandom_range(1, 6));
      endcase
    end
    idle(2);
    check("final_irq", {31'd0, irq}, {31'd0, exp_irq});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
